ibex_instr_mem_responder: RTL and testbench

// Responder (memory side) of the core's instruction fetch bus (req/gnt/rvalid, in-order, pipelined).

---
 rtl/ibex_instr_mem_responder.sv | 110 +++++++++++
 tb/tb_ibex_instr_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_instr_mem_responder.sv
// Memory-side responder for the instruction fetch bus (req/gnt/rvalid).
// Grants fetches, reads an internal backdoor-loadable RAM, and answers
// in order after a fixed latency through a small response queue.
module ibex_instr_mem_responder #(
   parameter logic [31:0] MemBase        = 32'h0000_0000,
   parameter int unsigned MemWords       = 1024,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned RespLatency    = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        instr_req_i,
   input  logic [31:0]                 instr_addr_i,
   output logic                        instr_gnt_o,
   output logic                        instr_rvalid_o,
   output logic [31:0]                 instr_rdata_o,
   output logic                        instr_err_o,
   input  logic                        gnt_stall_i,
   input  logic                        resp_stall_i,
   input  logic                        err_inject_i,
   input  logic                        load_we_i,
   input  logic [$clog2(MemWords)-1:0] load_addr_i,
   input  logic [31:0]                 load_wdata_i,
   output logic [2:0]                  outstanding_o,
   output logic                        busy_o
);

   localparam int unsigned AddrW   = $clog2(MemWords);
   localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   // 33 bits so a window ending exactly at 4 GiB does not wrap
   localparam logic [32:0] MemEnd  = {1'b0, MemBase} + 33'(4 * MemWords);
   localparam logic [1:0]  CntInit = 2'(RespLatency - 1);
   localparam logic [2:0]  CntMax  = 3'(MaxOutstanding);

   logic [31:0]      mem [MemWords];

   logic [31:0]      q_data [MaxOutstanding];
   logic             q_err  [MaxOutstanding];
   logic [1:0]       q_cnt  [MaxOutstanding];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [2:0]       count;

   logic             pop;
   logic             push;
   logic             req_err;
   logic [31:0]      addr_off;
   logic [AddrW-1:0] ram_idx;
   logic [31:0]      push_data;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(MaxOutstanding - 1)) return '0;
      return p + PtrW'(1);
   endfunction

   assign addr_off  = instr_addr_i - MemBase;
   assign ram_idx   = AddrW'(addr_off >> 2);
   assign req_err   = (instr_addr_i < MemBase) || ({1'b0, instr_addr_i} >= MemEnd) ||
                      (instr_addr_i[1:0] != 2'b00) || err_inject_i;
   // Errored fetches never expose RAM contents
   assign push_data = req_err ? 32'h0 : mem[ram_idx];

   // Head may leave once its latency has elapsed, unless the bench holds it back
   assign pop  = (count != 3'd0) && (q_cnt[rd_ptr] == 2'd0) && !resp_stall_i;
   // A pop frees a slot in the same cycle, so a full queue can still grant
   assign push = instr_req_i && !gnt_stall_i && ((count < CntMax) || pop);

   assign instr_gnt_o    = push;
   assign instr_rvalid_o = pop;
   assign instr_err_o    = pop && q_err[rd_ptr];
   assign instr_rdata_o  = (pop && !q_err[rd_ptr]) ? q_data[rd_ptr] : 32'h0;
   assign outstanding_o  = count;
   assign busy_o         = (count != 3'd0);

   // Backdoor RAM write; a same-cycle fetch of this word captures the old value
   always_ff @(posedge clk_i) begin
      if (load_we_i) mem[load_addr_i] <= load_wdata_i;
   end

   // Response queue: age all entries, enqueue on grant, dequeue on pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 3'd0;
         for (int i = 0; i < int'(MaxOutstanding); i++) begin
            q_data[i] <= 32'h0;
            q_err[i]  <= 1'b0;
            q_cnt[i]  <= 2'd0;
         end
      end else begin
         for (int i = 0; i < int'(MaxOutstanding); i++) begin
            if (q_cnt[i] != 2'd0) q_cnt[i] <= q_cnt[i] - 2'd1;
         end
         if (push) begin
            q_data[wr_ptr] <= push_data;
            q_err[wr_ptr]  <= req_err;
            q_cnt[wr_ptr]  <= CntInit;
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_ibex_instr_mem_responder;

   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int          WORDS = 64;
   localparam int          MAXO  = 2;
   localparam int          LAT   = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        gnt_stall_i;
   logic        resp_stall_i;
   logic        err_inject_i;
   logic        load_we_i;
   logic [5:0]  load_addr_i;
   logic [31:0] load_wdata_i;
   logic [2:0]  outstanding_o;
   logic        busy_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          ready;
   } resp_t;

   resp_t       mq[$];
   logic [31:0] mm [WORDS];
   int          cyc = 0;

   ibex_instr_mem_responder #(
      .MemBase(BASE), .MemWords(WORDS), .MaxOutstanding(MAXO), .RespLatency(LAT)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .gnt_stall_i(gnt_stall_i), .resp_stall_i(resp_stall_i),
      .err_inject_i(err_inject_i), .load_we_i(load_we_i),
      .load_addr_i(load_addr_i), .load_wdata_i(load_wdata_i),
      .outstanding_o(outstanding_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // One bus cycle: drive inputs, compare against the model, then advance the model
   task automatic step(input logic req, input logic [31:0] addr, input logic gs,
                       input logic rs, input logic einj, input logic we,
                       input logic [5:0] la, input logic [31:0] wd);
      logic        pop_e;
      logic        gnt_e;
      logic        bad;
      logic [31:0] d_e;
      logic        e_e;
      longint      a;
      resp_t       r;
      @(negedge clk_i);
      instr_req_i  = req;  instr_addr_i = addr; gnt_stall_i = gs;
      resp_stall_i = rs;   err_inject_i = einj; load_we_i   = we;
      load_addr_i  = la;   load_wdata_i = wd;
      #1;
      pop_e = 1'b0; d_e = 32'h0; e_e = 1'b0;
      if (mq.size() > 0) begin
         pop_e = (cyc >= mq[0].ready) && !rs;
         if (pop_e) begin
            e_e = mq[0].err;
            d_e = mq[0].err ? 32'h0 : mq[0].data;
         end
      end
      gnt_e = req && !gs && ((mq.size() < MAXO) || pop_e);
      check_eq("gnt", 32'(instr_gnt_o), 32'(gnt_e));
      check_eq("rvalid", 32'(instr_rvalid_o), 32'(pop_e));
      check_eq("rdata", instr_rdata_o, d_e);
      check_eq("err", 32'(instr_err_o), 32'(e_e));
      check_eq("outstanding", 32'(outstanding_o), 32'(mq.size()));
      check_eq("busy", 32'(busy_o), 32'(mq.size() != 0));
      if (pop_e) void'(mq.pop_front());
      if (gnt_e) begin
         a   = longint'(addr);
         bad = (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * WORDS) ||
               (addr[1:0] != 2'b00) || einj;
         r.err   = bad;
         r.data  = bad ? 32'h0 : mm[(addr - BASE) >> 2];
         r.ready = cyc + LAT;
         mq.push_back(r);
      end
      if (we) mm[la] = wd;
      cyc++;
   endtask

   task automatic idle(input int n, input logic rs);
      for (int i = 0; i < n; i++) step(0, 32'h0, 0, rs, 0, 0, 6'd0, 32'h0);
   endtask

   task automatic fetch(input logic [31:0] addr);
      step(1, addr, 0, 0, 0, 0, 6'd0, 32'h0);
   endtask

   // Asynchronous reset between clock edges; outputs must clear immediately
   task automatic do_reset();
      @(negedge clk_i);
      instr_req_i = 0; gnt_stall_i = 0; resp_stall_i = 0; err_inject_i = 0; load_we_i = 0;
      #2;
      rst_ni = 1'b0;
      #1;
      check_eq("rst_rvalid", 32'(instr_rvalid_o), 32'h0);
      check_eq("rst_err", 32'(instr_err_o), 32'h0);
      check_eq("rst_rdata", instr_rdata_o, 32'h0);
      check_eq("rst_outstanding", 32'(outstanding_o), 32'h0);
      check_eq("rst_busy", 32'(busy_o), 32'h0);
      mq.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         6:       return BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
         7:       return BASE - 4 * $urandom_range(1, 8);
         8:       return BASE + 4 * WORDS + 4 * $urandom_range(0, 8);
         9:       return 32'hFFFF_FFFC;
         default: return BASE + 4 * $urandom_range(0, WORDS - 1);
      endcase
   endfunction

   initial begin
      rst_ni = 1'b0;
      instr_req_i = 0; instr_addr_i = 0; gnt_stall_i = 0; resp_stall_i = 0;
      err_inject_i = 0; load_we_i = 0; load_addr_i = 0; load_wdata_i = 0;
      repeat (3) @(negedge clk_i);
      #1;
      check_eq("init_rvalid", 32'(instr_rvalid_o), 32'h0);
      check_eq("init_outstanding", 32'(outstanding_o), 32'h0);
      check_eq("init_busy", 32'(busy_o), 32'h0);
      rst_ni = 1'b1;

      for (int i = 0; i < WORDS; i++) step(0, 32'h0, 0, 0, 0, 1, 6'(i), $urandom);
      step(0, 32'h0, 0, 0, 0, 1, 6'd0, 32'h0000_0013);

      // single fetch of word 0
      fetch(BASE);
      idle(LAT + 1, 0);

      // back-to-back pipelined fetches with the requester holding req
      begin
         int k = 0;
         for (int t = 0; t < 12 && k < 3; t++) begin
            step(1, BASE + 4 * k, 0, 0, 0, 0, 6'd0, 32'h0);
            if (instr_gnt_o) k++;
         end
         check_eq("b2b_grants", 32'(k), 32'd3);
      end
      idle(LAT + 2, 0);

      // out-of-window and misaligned addresses, and injected error
      fetch(BASE + 4 * WORDS);
      fetch(BASE + 2);
      idle(LAT + 1, 0);
      fetch(BASE - 4);
      step(1, BASE + 8, 0, 0, 1, 0, 6'd0, 32'h0);
      idle(LAT + 1, 0);

      // grant stall with req held
      for (int i = 0; i < 3; i++) step(1, BASE + 12, 1, 0, 0, 0, 6'd0, 32'h0);
      fetch(BASE + 12);
      idle(LAT + 1, 0);

      // response stall with two outstanding
      fetch(BASE + 16);
      fetch(BASE + 20);
      idle(2, 1);
      idle(LAT + 2, 0);

      // backdoor write collides with a granted read of the same word
      step(1, BASE + 20, 0, 0, 0, 1, 6'd5, 32'hCAFE_F00D);
      fetch(BASE + 20);
      idle(LAT + 2, 0);

      // reset with two outstanding, then resume
      step(1, BASE + 4, 0, 1, 0, 0, 6'd0, 32'h0);
      step(1, BASE + 8, 0, 1, 0, 0, 6'd0, 32'h0);
      do_reset();
      idle(LAT + 2, 0);
      fetch(BASE);
      idle(LAT + 1, 0);

      // random traffic with one mid-run reset
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         step($urandom_range(0, 3) != 0, rand_addr(),
              $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              6'($urandom_range(0, WORDS - 1)), $urandom);
      end
      idle(LAT + 4, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
